// File: rtl/debug_slave_pkg.sv
// Shared constants, bit-index helpers and the FIFO entry layout for the debug slave command path.
package debug_slave_pkg;

  localparam int unsigned IrWDefault   = 2;
  localparam int unsigned SrWDefault   = 38;
  localparam int unsigned NchDefault   = 4;
  localparam int unsigned DepthDefault = 4;

  function automatic int unsigned action_bit(int unsigned sr_w);
    return sr_w - 1;
  endfunction

  function automatic int unsigned parity_bit(int unsigned sr_w);
    return sr_w - 2;
  endfunction

  typedef struct packed {
    logic [IrWDefault-1:0] ir;
    logic [SrWDefault-1:0] data;
  } cmd_entry_t;

endpackage

// File: rtl/debug_slave_cmd_fifo.sv
// Single-clock command FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module debug_slave_cmd_fifo #(
  parameter int unsigned W     = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       push_ok
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          pop_en;

  assign valid   = (level_q != '0);
  assign pop_en  = pop & valid;
  assign push_ok = push & ((level_q < LW'(DEPTH)) | pop_en);
  assign rdata   = mem[rd_ptr_q];
  assign level   = level_q;

  // Storage carries no reset; only the pointers and level define what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case ({push_ok, pop_en})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/debug_slave_cmd_sync.sv
// Moves JTAG update-IR/update-DR commands into the clk domain, queues them and decodes action pulses.
// Optional feature: DEBUG_SLAVE_CMD_PARITY_EN adds even-parity checking of sr and a parity_err flag.
module debug_slave_cmd_sync
  import debug_slave_pkg::*;
#(
  parameter int unsigned IR_W  = IrWDefault,
  parameter int unsigned SR_W  = SrWDefault,
  parameter int unsigned NCH   = NchDefault,
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vs_uir,
  input  logic                     vs_udr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          cmd_data,
  output logic [NCH-1:0]           take_action,
  output logic [NCH-1:0]           take_no_action,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     bad_ir,
  input  logic                     err_clr
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned ActBit = action_bit(SR_W);
  localparam int unsigned EW     = IR_W + SR_W;

  logic [2:0]      uir_sync_q, udr_sync_q, fill_q;
  logic            uir_evt, udr_evt;
  logic [IR_W-1:0] ir_q;
  logic            parity_bad, push_req, push_ok, pop;
  logic [EW-1:0]   head;
  logic [NCH-1:0]  chan_sel, act_d, noact_d, act_q, noact_q;
  logic            bad_set, overflow_d, overflow_q, bad_ir_d, bad_ir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      fill_q     <= '0;
    end else begin
      uir_sync_q <= {uir_sync_q[1:0], vs_uir};
      udr_sync_q <= {udr_sync_q[1:0], vs_udr};
      fill_q     <= {fill_q[1:0], 1'b1};
    end
  end

  // Edges are only trusted once stage 3 holds a real sample, so a level already high
  // at reset release never looks like a rising edge.
  assign uir_evt = fill_q[2] & uir_sync_q[1] & ~uir_sync_q[2];
  assign udr_evt = fill_q[2] & udr_sync_q[1] & ~udr_sync_q[2];

  // The push below reads ir_q before this update lands, so a coincident uir uses the old code.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= '0;
    end else if (uir_evt) begin
      ir_q <= ir_in;
    end
  end

`ifdef DEBUG_SLAVE_CMD_PARITY_EN
  logic parity_err_q;
  // Even parity over the whole register, parity bit included, must reduce to zero.
  assign parity_bad = ^sr;
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= (parity_err_q & ~err_clr) | (udr_evt & parity_bad);
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_bad = 1'b0;
`endif

  assign push_req = udr_evt & ~parity_bad;
  assign pop      = cmd_valid & cmd_ready;

  debug_slave_cmd_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .wdata   ({ir_q, sr}),
    .pop     (pop),
    .rdata   (head),
    .valid   (cmd_valid),
    .level   (fifo_level),
    .push_ok (push_ok)
  );

  assign cmd_ir   = head[EW-1 -: IR_W];
  assign cmd_data = head[SR_W-1:0];
  assign chan_sel = NCH'(1) << cmd_ir;

  always_comb begin
    act_d      = '0;
    noact_d    = '0;
    bad_set    = 1'b0;
    if (pop) begin
      if (32'(cmd_ir) < NCH) begin
        if (cmd_data[ActBit]) begin
          act_d = chan_sel;
        end else begin
          noact_d = chan_sel;
        end
      end else begin
        bad_set = 1'b1;
      end
    end
    overflow_d = (overflow_q & ~err_clr) | (push_req & ~push_ok);
    bad_ir_d   = (bad_ir_q & ~err_clr) | bad_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= '0;
      noact_q    <= '0;
      overflow_q <= 1'b0;
      bad_ir_q   <= 1'b0;
    end else begin
      act_q      <= act_d;
      noact_q    <= noact_d;
      overflow_q <= overflow_d;
      bad_ir_q   <= bad_ir_d;
    end
  end

  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign overflow       = overflow_q;
  assign bad_ir         = bad_ir_q;

endmodule

// File: tb/tb_debug_slave_cmd_sync.sv
// Randomised scoreboard bench for debug_slave_cmd_sync (NCH=3 so that IR code 3 is out of range).
module tb_debug_slave_cmd_sync;
  import debug_slave_pkg::*;

  localparam int IR_W  = 2;
  localparam int SR_W  = 38;
  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            vs_uir = 1'b0, vs_udr = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            cmd_valid, cmd_ready = 1'b0;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] cmd_data;
  logic [NCH-1:0]  take_action, take_no_action;
  logic [2:0]      fifo_level;
  logic            overflow, bad_ir, err_clr = 1'b0;
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
  logic            parity_err;
`endif

  debug_slave_cmd_sync #(
    .IR_W  (IR_W),
    .SR_W  (SR_W),
    .NCH   (NCH),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .vs_uir         (vs_uir),
    .vs_udr         (vs_udr),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .bad_ir         (bad_ir),
    .err_clr        (err_clr)
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
    ,
    .parity_err     (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of commands the DUT must deliver, plus expected sticky flags.
  cmd_entry_t      exp_q[$];
  logic [NCH-1:0]  exp_act = '0, exp_no = '0;
  bit              exp_ovf = 0, exp_bad = 0, exp_par = 0;
  logic [IR_W-1:0] model_ir = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [SR_W-1:0] mk_sr(bit act);
    logic [SR_W-1:0] s;
    s = {6'($urandom), 32'($urandom)};
    s[SR_W-1] = act;
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
    s[SR_W-2] = 1'b0;
    s[SR_W-2] = ^s;
`endif
    return s;
  endfunction

  // Scoreboard monitor: checks pulses every cycle and pops expectations on each handshake.
  always @(negedge clk) begin
    cmd_entry_t e;
    if (reset) begin
      exp_act = '0;
      exp_no  = '0;
    end else begin
      check("take_action", 64'(take_action), 64'(exp_act));
      check("take_no_action", 64'(take_no_action), 64'(exp_no));
      exp_act = '0;
      exp_no  = '0;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got cmd_ir=%0h data=%0h, expected no entry", cmd_ir,
                   cmd_data);
        end else begin
          e = exp_q.pop_front();
          check("cmd_ir", 64'(cmd_ir), 64'(e.ir));
          check("cmd_data", 64'(cmd_data), 64'(e.data));
          if (e.ir < NCH) begin
            if (e.data[SR_W-1]) exp_act = NCH'(1) << e.ir;
            else                exp_no  = NCH'(1) << e.ir;
          end else begin
            exp_bad = 1;
          end
        end
      end
    end
  end

  // Raise the requested update levels long enough for synchronisation, holding data stable.
  task automatic issue(bit u, bit d, logic [IR_W-1:0] ir, logic [SR_W-1:0] s);
    ir_in  = ir;
    sr     = s;
    vs_uir = u;
    vs_udr = d;
    if (d) begin
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
      if (^s) exp_par = 1;
      else
`endif
      if (exp_q.size() < DEPTH) exp_q.push_back('{ir: model_ir, data: s});
      else exp_ovf = 1;
    end
    if (u) model_ir = ir;
    step(5);
    vs_uir = 1'b0;
    vs_udr = 1'b0;
    step(4);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cmd_valid) && n < 300) begin
      cmd_ready = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d entries still expected, expected 0", exp_q.size());
    end
    cmd_ready = 1'b0;
    step(2);
  endtask

  task automatic check_flags();
    check("overflow", 64'(overflow), 64'(exp_ovf));
    check("bad_ir", 64'(bad_ir), 64'(exp_bad));
`ifdef DEBUG_SLAVE_CMD_PARITY_EN
    check("parity_err", 64'(parity_err), 64'(exp_par));
`endif
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    exp_ovf = 0;
    exp_bad = 0;
    exp_par = 0;
    step(1);
    check_flags();
  endtask

  initial begin
    logic [SR_W-1:0] s;
    int n, kind;

    step(3);
    reset = 1'b0;
    step(1);
    check("reset_cmd_valid", 64'(cmd_valid), 64'(0));
    check("reset_fifo_level", 64'(fifo_level), 64'(0));
    check_flags();

    // Single action command on channel 1, consumer always ready.
    cmd_ready = 1'b1;
    issue(1, 0, 2'd1, '0);
    issue(0, 1, 2'd0, mk_sr(1));
    drain();
    check_flags();

    // Overfill: five pushes into four slots.
    for (int i = 0; i < 5; i++) issue(0, 1, 2'd0, mk_sr(1'($urandom)));
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    check_flags();
    clear_flags();

    // Push while full with a pop in the same cycle (3-flop sync puts the push on the 3rd edge).
    s = mk_sr(1'($urandom));
    sr = s;
    vs_udr = 1'b1;
    exp_q.push_back('{ir: model_ir, data: s});
    step(2);
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    vs_udr = 1'b0;
    step(4);
    check("push_pop_full_level", 64'(fifo_level), 64'(DEPTH));
    check_flags();
    drain();

    // Reset with entries queued and vs_udr held high across release.
    for (int i = 0; i < 3; i++) issue(0, 1, 2'd0, mk_sr(1'($urandom)));
    check("pre_reset_level", 64'(fifo_level), 64'(3));
    vs_udr = 1'b1;
    sr = mk_sr(1);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 0;
    exp_bad = 0;
    exp_par = 0;
    model_ir = '0;
    step(8);
    check("post_reset_level", 64'(fifo_level), 64'(0));
    check("post_reset_valid", 64'(cmd_valid), 64'(0));
    vs_udr = 1'b0;
    step(4);
    check("post_release_level", 64'(fifo_level), 64'(0));
    check_flags();

    // Coincident uir/udr: entry uses old ir_q (0), next one the new code (3, out of range).
    issue(1, 1, 2'd3, mk_sr(1));
    issue(0, 1, 2'd0, mk_sr(0));
    drain();
    check_flags();
    clear_flags();

`ifdef DEBUG_SLAVE_CMD_PARITY_EN
    s = mk_sr(1);
    s[SR_W-2] = ~s[SR_W-2];
    issue(0, 1, 2'd0, s);
    check("parity_level", 64'(fifo_level), 64'(0));
    check_flags();
    clear_flags();
`endif

    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 2);
        issue(kind != 1, kind != 0, 2'($urandom), mk_sr(1'($urandom)));
      end
      check("rand_level", 64'(fifo_level), 64'(exp_q.size()));
      drain();
      check_flags();
      clear_flags();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
